cdb_arbiter: RTL



---
 rtl/cdb_arbiter_pkg.sv | 26 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 37 +++
 rtl/cdb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the Common Data Bus arbiter: requester count,
// source indices and the CDB_PACKET broadcast format.
// No ports (package).
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

    // Requester count and fixed source positions on the arbiter.
    localparam int CDB_NUM_REQ  = 3;
    localparam int CDB_SRC_ALU  = 0;
    localparam int CDB_SRC_MULT = 1;
    localparam int CDB_SRC_LSQ  = 2;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    // Result broadcast. .valid qualifies the packet on the CDB; on the
    // requester side it is ignored (req_valid is the qualifier).
    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Grants the first asserted request at
// or after index ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req  [NUM_REQ]  request vector
//   ptr  [PTR_W]    highest-priority index this cycle
//   gnt  [NUM_REQ]  one-hot grant, all zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic found;
    int   idx;

    // Walk the requesters in priority order starting at ptr; the first hit
    // wins and later hits are masked by found.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the single Common Data Bus between the result sources (ALU, MULT,
// LSQ load return). Each source has a one-entry holding buffer; a
// round-robin arbiter picks one buffered result per cycle and drives a
// registered broadcast packet. Squash empties everything in flight.
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   squash      mispredict flush, synchronous, level-sensitive
//   req_valid   [NUM_REQ] requester i presents a result
//   req_packet  [NUM_REQ] result payload per requester
//   req_ready   [NUM_REQ] requester i may hand off this cycle
//   cdb_packet  registered broadcast; .valid qualifies it
//   grant_oh    [NUM_REQ] registered one-hot source of cdb_packet
// ---------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic [NUM_REQ-1:0] req_valid,
    input  CDB_PACKET          req_packet [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output CDB_PACKET          cdb_packet,
    output logic [NUM_REQ-1:0] grant_oh
);

    logic [NUM_REQ-1:0] hold_valid;
    CDB_PACKET          hold_pkt [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] accept;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   next_ptr;
    CDB_PACKET          granted_pkt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req (hold_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    // Handshake: a requester transfers on an edge where req_valid[i] and
    // req_ready[i] are both high. req_ready[i] is high when the buffer is
    // empty or is being drained by this cycle's grant, and never during
    // squash. Once req_valid is raised and not yet accepted, the requester
    // keeps req_valid/req_packet stable.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !squash && (!hold_valid[i] || gnt[i]);
        end
        accept = req_valid & req_ready;
    end

    // Encode the one-hot grant and work out the pointer that follows it.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = PTR_W'(i);
        end
        next_ptr = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        granted_pkt       = hold_pkt[gnt_idx];
        granted_pkt.valid = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) hold_pkt[i] <= '0;
            rr_ptr     <= '0;
            cdb_packet <= '0;
            grant_oh   <= '0;
        end else if (squash) begin
            // Flush: no arbitration, pointer left where it was.
            hold_valid       <= '0;
            cdb_packet.valid <= 1'b0;
            grant_oh         <= '0;
        end else begin
            // A granted buffer that also accepts is reloaded in place,
            // so a streaming source sees no bubble.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_pkt[i]   <= req_packet[i];
                end else if (gnt[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            if (|gnt) begin
                cdb_packet <= granted_pkt;
                grant_oh   <= gnt;
                rr_ptr     <= next_ptr;
            end else begin
                // Payload fields keep their last value; only valid drops.
                cdb_packet.valid <= 1'b0;
                grant_oh         <= '0;
            end
        end
    end

endmodule
